data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 21 ++
 rtl/dmem_lane_align.sv | 46 ++++
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 tb/tb_data_mem_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data memory responder: bus width, access sizes and FSM states.
package data_mem_responder_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } state_e;

    // Encoding 2'b11 behaves exactly like a word access.
    function automatic logic size_is_word(logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables / replicated store data and
// load extraction with sign or zero extension.
module dmem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [3:0]        byte_en,
    output logic [DATA_W-1:0] wdata_aligned,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Half accesses use offset[1] only and word accesses ignore the offset, so
    // misaligned addresses fall onto the containing aligned lanes.
    always_comb begin
        byte_en       = 4'b0000;
        wdata_aligned = '0;
        rdata_ext     = '0;
        rbyte         = rword[{offset, 3'b000} +: 8];
        rhalf         = offset[1] ? rword[31:16] : rword[15:0];
        unique case (size)
            SIZE_BYTE: begin
                byte_en       = 4'b0001 << offset;
                wdata_aligned = {4{wdata[7:0]}};
                rdata_ext     = is_unsigned ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            SIZE_HALF: begin
                byte_en       = offset[1] ? 4'b1100 : 4'b0011;
                wdata_aligned = {2{wdata[15:0]}};
                rdata_ext     = is_unsigned ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            default: begin
                byte_en       = 4'b1111;
                wdata_aligned = wdata;
                rdata_ext     = rword;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store at a time, waits WAIT_CYCLES, then
// holds the response until the core takes it.
// Optional feature macro DMEM_ALIGN_CHECK_EN: reject misaligned half/word accesses
// with respErr instead of silently aligning them.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [1:0]        reqSize,
    input  logic              reqUnsigned,
    input  logic [31:0]       reqAddr,
    input  logic [DATA_W-1:0] reqWData,
    output logic              respValid,
    input  logic              respReady,
    output logic [DATA_W-1:0] respRData,
    output logic              respErr
);

    localparam int unsigned IdxW     = $clog2(DEPTH);
    localparam logic [3:0]  WaitInit = WAIT_CYCLES[3:0];

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, uns_q;
    logic [1:0]        size_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept, enter_resp;
    logic              cur_wr, cur_uns, cur_err;
    logic [1:0]        cur_size;
    logic [31:0]       cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [IdxW-1:0]   idx;
    logic [3:0]        byte_en;
    logic [DATA_W-1:0] wdata_aligned, rdata_ext;
    logic              unused_addr_hi;

    assign reqReady  = (state_q == StIdle);
    assign respValid = (state_q == StResp);
    assign respRData = rdata_q;
    assign respErr   = err_q;
    assign accept    = reqValid && reqReady;

    // With zero wait states the commit happens on the accept edge, so the live request
    // fields are used in IDLE and the latched copy everywhere else.
    assign cur_wr    = (state_q == StIdle) ? reqWrite    : wr_q;
    assign cur_uns   = (state_q == StIdle) ? reqUnsigned : uns_q;
    assign cur_size  = (state_q == StIdle) ? reqSize     : size_q;
    assign cur_addr  = (state_q == StIdle) ? reqAddr     : addr_q;
    assign cur_wdata = (state_q == StIdle) ? reqWData    : wdata_q;

    assign idx            = cur_addr[IdxW+1:2];
    assign unused_addr_hi = ^cur_addr[31:IdxW+2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign cur_err = (cur_size == SIZE_HALF && cur_addr[0]) ||
                     (size_is_word(cur_size) && cur_addr[1:0] != 2'b00);
`else
    assign cur_err = 1'b0;
`endif

    assign enter_resp = (state_q == StIdle && accept && WAIT_CYCLES == 0) ||
                        (state_q == StWait && cnt_q <= 4'd1);

    dmem_lane_align u_lane_align (
        .size          (cur_size),
        .offset        (cur_addr[1:0]),
        .is_unsigned   (cur_uns),
        .wdata         (cur_wdata),
        .rword         (mem[idx]),
        .byte_en       (byte_en),
        .wdata_aligned (wdata_aligned),
        .rdata_ext     (rdata_ext)
    );

    // Next-state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d   = WaitInit;
                    state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = StResp;
            end
            StResp: begin
                if (respReady) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, request latch and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= reqWrite;
                uns_q   <= reqUnsigned;
                size_q  <= reqSize;
                addr_q  <= reqAddr;
                wdata_q <= reqWData;
            end
            if (enter_resp) begin
                rdata_q <= (cur_wr || cur_err) ? '0 : rdata_ext;
                err_q   <= cur_err;
            end
        end
    end

    // Storage is never reset; a write needs reset released so an aborted store is dropped.
    always_ff @(posedge clk) begin
        if (enter_resp && reset && cur_wr && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_aligned[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT_CYCLES 2 and 0) driven with directed
// and random transactions, checked against a byte-array reference model.
module tb_data_mem_responder;

    localparam int W0 = 2;
    localparam int W1 = 0;

    logic        clk;
    logic        reset;
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic        req_write   [2];
    logic [1:0]  req_size    [2];
    logic        req_uns     [2];
    logic [31:0] req_addr    [2];
    logic [31:0] req_wdata   [2];
    logic        resp_valid  [2];
    logic        resp_ready  [2];
    logic [31:0] resp_rdata  [2];
    logic        resp_err    [2];

    logic [7:0]  mb [2][1024];
    int          n_checks = 0;
    int          n_fails  = 0;

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .reset(reset),
        .reqValid(req_valid[0]), .reqReady(req_ready[0]), .reqWrite(req_write[0]),
        .reqSize(req_size[0]), .reqUnsigned(req_uns[0]), .reqAddr(req_addr[0]),
        .reqWData(req_wdata[0]), .respValid(resp_valid[0]), .respReady(resp_ready[0]),
        .respRData(resp_rdata[0]), .respErr(resp_err[0])
    );

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .reset(reset),
        .reqValid(req_valid[1]), .reqReady(req_ready[1]), .reqWrite(req_write[1]),
        .reqSize(req_size[1]), .reqUnsigned(req_uns[1]), .reqAddr(req_addr[1]),
        .reqWData(req_wdata[1]), .respValid(resp_valid[1]), .respReady(resp_ready[1]),
        .respRData(resp_rdata[1]), .respErr(resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: memory as 1024 bytes (DEPTH*4), accesses by byte count.
    function automatic void model_access(input int d, input bit wr, input logic [1:0] size,
                                         input bit uns, input logic [31:0] addr,
                                         input logic [31:0] wdata,
                                         output logic [31:0] rdata, output bit err);
        int nb;
        int a;
        logic [31:0] v;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        a = int'(addr % 1024);
        err = 1'b0;
        rdata = '0;
`ifdef DMEM_ALIGN_CHECK_EN
        if (a % nb != 0) err = 1'b1;
`endif
        a = a - (a % nb);
        if (err) return;
        if (wr) begin
            for (int i = 0; i < nb; i++) mb[d][a+i] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[d][a+i];
            if (!uns && v[8*nb-1]) begin
                for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
            end
            rdata = v;
        end
    endfunction

    task automatic do_req(input int d, input bit wr, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          output logic [31:0] got_rdata, output logic got_err);
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          lat;
        model_access(d, wr, size, uns, addr, wdata, exp_rdata, exp_err);
        @(negedge clk);
        req_write[d] = wr;
        req_size[d]  = size;
        req_uns[d]   = uns;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        check_eq("req_ready_idle", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        // Post-accept changes must not leak into the transaction.
        req_valid[d] = 1'b0;
        req_write[d] = 1'($urandom);
        req_size[d]  = 2'($urandom);
        req_uns[d]   = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        lat = 1;
        while (!resp_valid[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", 32'(lat), (d == 0) ? 32'(W0 + 1) : 32'(W1 + 1));
        got_rdata = resp_rdata[d];
        got_err   = resp_err[d];
        check_eq("rdata", got_rdata, exp_rdata);
        check_eq("err", 32'(got_err), 32'(exp_err));
        for (int k = 0; k < hold; k++) begin
            req_valid[d] = 1'b1;
            req_addr[d]  = $urandom;
            @(posedge clk);
            #1;
            check_eq("hold_valid", 32'(resp_valid[d]), 32'd1);
            check_eq("hold_rdata", resp_rdata[d], exp_rdata);
            check_eq("hold_err", 32'(resp_err[d]), 32'(exp_err));
            check_eq("hold_ready", 32'(req_ready[d]), 32'd0);
        end
        req_valid[d] = 1'b0;
        @(negedge clk);
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[d] = 1'b0;
        check_eq("resp_done", 32'(resp_valid[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        logic [31:0] w10;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0; req_uns[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_ready", 32'(req_ready[d]), 32'd1);
            check_eq("rst_valid", 32'(resp_valid[d]), 32'd0);
            check_eq("rst_rdata", resp_rdata[d], 32'd0);
            check_eq("rst_err", 32'(resp_err[d]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Give every word a known value.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 256; w++) do_req(d, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0, r, e);
        end

        // Word store then load.
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, r, e);
        check_eq("store_rdata_zero", r, 32'd0);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, r, e);
        check_eq("word_load", r, 32'hDEADBEEF);

        // Byte store, signed/unsigned byte loads, word readback.
        do_req(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h80, 0, r, e);
        do_req(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, r, e);
        check_eq("byte_signed", r, 32'hFFFFFF80);
        do_req(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, r, e);
        check_eq("byte_unsigned", r, 32'h00000080);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, r, e);
        check_eq("word_after_byte", r, 32'h80ADBEEF);

        // Back-pressure on the response.
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, r, e);

        // Misaligned word store.
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h12, 32'hCAFEF00D, 0, r, e);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, w10, e);
`ifdef DMEM_ALIGN_CHECK_EN
        check_eq("misalign_word_0x10", w10, 32'h80ADBEEF);
`else
        check_eq("misalign_word_0x10", w10, 32'hCAFEF00D);
`endif

        // Reset during the wait of a store: no commit, outputs return to reset values.
        @(negedge clk);
        req_write[0] = 1'b1; req_size[0] = 2'd2; req_uns[0] = 1'b0;
        req_addr[0] = 32'h20; req_wdata[0] = 32'h55; req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        check_eq("wait_ready", 32'(req_ready[0]), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_ready", 32'(req_ready[0]), 32'd1);
        check_eq("arst_valid", 32'(resp_valid[0]), 32'd0);
        check_eq("arst_rdata", resp_rdata[0], 32'd0);
        check_eq("arst_err", 32'(resp_err[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, r, e);

        // Zero wait states and address wrap.
        do_req(1, 1'b1, 2'd2, 1'b0, 32'h0, 32'h1234ABCD, 0, r, e);
        do_req(1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0, r, e);
        check_eq("wrap_load", r, 32'h1234ABCD);

        // Random traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            do_req(int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), 1'($urandom),
                   $urandom, $urandom, int'($urandom_range(0, 2)), r, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
